// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA 640x480@60 timing constants, colour layout and helpers.
package vga_pkg;
  localparam int H_VIS = 640;
  localparam int H_FP = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP = 48;
  localparam int V_VIS = 480;
  localparam int V_FP = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP = 33;
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_VIS + H_FP;
  localparam int H_SYNC_END = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_VIS + V_FP;
  localparam int V_SYNC_END = V_SYNC_START + V_SYNC - 1;
  localparam int COLOUR_W = 8;
  localparam int R_HI = 7;
  localparam int R_LO = 5;
  localparam int G_HI = 4;
  localparam int G_LO = 2;
  localparam int B_HI = 1;
  localparam int B_LO = 0;
  typedef logic [COLOUR_W-1:0] colour_t;
  localparam colour_t BLACK = '0;
  function automatic logic inRange(input logic [9:0] val, input int lo, input int hi);
    return (int'(val) >= lo) && (int'(val) <= hi);
  endfunction
endpackage

// File: rtl/vga_sync_generator_mod_counter.sv
// mod_counter: enabled modulo-MOD counter; WRAP flags the enabled terminal count.
module mod_counter #(
  parameter int MOD = 4,
  parameter int W = $clog2(MOD)
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         EN,
  output logic [W-1:0] CNT,
  output logic         WRAP
);
  assign WRAP = EN && (CNT == W'(MOD - 1));
  always_ff @(posedge CLK)
    if (RESET) CNT <= '0;
    else if (EN) CNT <= WRAP ? '0 : CNT + 1'b1;
endmodule

// File: rtl/vga_sync_generator.sv
// vga_sync_generator: VGA timing, pixel addressing and one-pixel-delayed colour/sync output.
module vga_sync_generator #(
  parameter int PIX_DIV = 4,
  parameter int H_VIS = vga_pkg::H_VIS,
  parameter int H_FP = vga_pkg::H_FP,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BP = vga_pkg::H_BP,
  parameter int V_VIS = vga_pkg::V_VIS,
  parameter int V_FP = vga_pkg::V_FP,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BP = vga_pkg::V_BP
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] COLOUR_IN,
  output logic [9:0] ADDRH,
  output logic [8:0] ADDRV,
  output logic       PIXEL_TICK,
  output logic       HS,
  output logic       VS,
  output logic [7:0] COLOUR_OUT,
  output logic       FRAME_TICK
);
  import vga_pkg::*;
  localparam int HTOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int VTOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HSS = H_VIS + H_FP;
  localparam int VSS = V_VIS + V_FP;
  localparam int DW = $clog2(PIX_DIV);
  logic [DW-1:0] divCnt;
  logic [9:0] hCnt, vCnt;
  logic divWrap, hWrap, vWrap, vis;
  mod_counter #(.MOD(PIX_DIV), .W(DW)) uDiv (.CLK(CLK), .RESET(RESET), .EN(1'b1), .CNT(divCnt), .WRAP(divWrap));
  mod_counter #(.MOD(HTOT), .W(10)) uH (.CLK(CLK), .RESET(RESET), .EN(PIXEL_TICK), .CNT(hCnt), .WRAP(hWrap));
  mod_counter #(.MOD(VTOT), .W(10)) uV (.CLK(CLK), .RESET(RESET), .EN(hWrap), .CNT(vCnt), .WRAP(vWrap));
  assign PIXEL_TICK = divWrap && (divCnt == DW'(PIX_DIV - 1));
  assign vis = (hCnt < 10'(H_VIS)) && (vCnt < 10'(V_VIS));
  assign ADDRH = vis ? hCnt : '0;
  assign ADDRV = vis ? vCnt[8:0] : '0;
  // Sync and colour use the pre-increment pixel, so all three lag the address by one pixel.
  always_ff @(posedge CLK)
    if (RESET) begin
      HS <= 1'b1;
      VS <= 1'b1;
      COLOUR_OUT <= BLACK;
      FRAME_TICK <= 1'b0;
    end else begin
      FRAME_TICK <= vWrap;
      if (PIXEL_TICK) begin
        HS <= ~inRange(hCnt, HSS, HSS + H_SYNC - 1);
        VS <= ~inRange(vCnt, VSS, VSS + V_SYNC - 1);
        COLOUR_OUT <= vis ? COLOUR_IN : BLACK;
      end
    end
endmodule

// File: tb/tb_vga_sync_generator.sv
// tb_vga_sync_generator: scaled-timing run against a cycle-index arithmetic model.
module tb_vga_sync_generator;
  localparam int D = 3;
  localparam int HV = 8, HF = 2, HSY = 3, HB = 2;
  localparam int VV = 4, VF = 1, VSY = 2, VB = 2;
  localparam int HT = HV + HF + HSY + HB;
  localparam int VT = VV + VF + VSY + VB;
  localparam int FR = D * HT * VT;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic [7:0] COLOUR_IN = '0;
  logic [9:0] ADDRH;
  logic [8:0] ADDRV;
  logic PIXEL_TICK, HS, VS, FRAME_TICK;
  logic [7:0] COLOUR_OUT;
  int checks = 0;
  int errors = 0;
  int k = 0;
  logic [7:0] lastCol = '0;
  bit renderMode = 0;

  vga_sync_generator #(
    .PIX_DIV(D), .H_VIS(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB)
  ) dut (
    .CLK(CLK), .RESET(RESET), .COLOUR_IN(COLOUR_IN), .ADDRH(ADDRH), .ADDRV(ADDRV),
    .PIXEL_TICK(PIXEL_TICK), .HS(HS), .VS(VS), .COLOUR_OUT(COLOUR_OUT), .FRAME_TICK(FRAME_TICK)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s k=%0d got %0h exp %0h", tag, k, got, exp);
    end
  endtask

  function automatic int addrH(input int kk);
    int n = kk / D;
    int h = n % HT;
    int v = (n / HT) % VT;
    return (h < HV && v < VV) ? h : 0;
  endfunction

  task automatic checkCycle();
    int n = k / D;
    int h = n % HT;
    int v = (n / HT) % VT;
    bit vis = (h < HV) && (v < VV);
    int hp, vp;
    logic eHs = 1'b1, eVs = 1'b1;
    logic [7:0] eCol = 8'h00;
    if (n > 0) begin
      hp = (n - 1) % HT;
      vp = ((n - 1) / HT) % VT;
      eHs = !(hp >= HV + HF && hp < HV + HF + HSY);
      eVs = !(vp >= VV + VF && vp < VV + VF + VSY);
      eCol = (hp < HV && vp < VV) ? lastCol : 8'h00;
    end
    chk("PIXEL_TICK", 32'(PIXEL_TICK), 32'(k % D == D - 1));
    chk("ADDRH", 32'(ADDRH), vis ? h : 0);
    chk("ADDRV", 32'(ADDRV), vis ? v : 0);
    chk("HS", 32'(HS), 32'(eHs));
    chk("VS", 32'(VS), 32'(eVs));
    chk("COLOUR_OUT", 32'(COLOUR_OUT), 32'(eCol));
    chk("FRAME_TICK", 32'(FRAME_TICK), 32'(k > 0 && k % FR == 0));
  endtask

  task automatic step();
    logic [7:0] c;
    @(negedge CLK);
    checkCycle();
    c = renderMode ? 8'(addrH(k)) : 8'($urandom);
    COLOUR_IN = c;
    if (k % D == D - 1) lastCol = c;
    k++;
  endtask

  task automatic resetHold(input int n);
    @(negedge CLK);
    RESET = 1'b1;
    repeat (n) begin
      @(negedge CLK);
      k = 0;
      COLOUR_IN = 8'($urandom);
      checkCycle();
    end
    RESET = 1'b0;
    k = 1;
  endtask

  initial begin
    resetHold(5);
    repeat (2 * FR + 50) step();
    renderMode = 1;
    repeat (FR) step();
    renderMode = 0;
    repeat ($urandom_range(10, FR)) step();
    resetHold(1);
    repeat (2 * FR + 10) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
